// File: rtl/rbm_pkg.sv
// rbm_pkg: shared constants and types for the bit-serial RBM inference core.
//   N_VIS       visible pixels per hidden unit (bias arrives at index N_VIS)
//   N_HID       hidden units per class (bias arrives at index N_HID)
//   DW          weight / bias / accumulator width, signed two's complement
//   APPROX_BITS low-order bits discarded by the approximate adder
package rbm_pkg;

  localparam int N_VIS       = 784;
  localparam int N_HID       = 441;
  localparam int DW          = 64;
  localparam int APPROX_BITS = 16;

  localparam int PIX_W = 10;  // width of pixel_id
  localparam int HID_W = 9;   // width of hidden_id

  typedef logic signed [DW-1:0] acc_t;

  // AND-mask that clears the bits the approximate adder ignores.
  localparam acc_t APPROX_KEEP = acc_t'({{(DW-APPROX_BITS){1'b1}}, {APPROX_BITS{1'b0}}});

endpackage

// File: rtl/rbm_mac.sv
// rbm_mac: one gated accumulate-and-threshold unit.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   en            phase active (already qualified against the other phase)
//   idx           term index; 0 restarts the sum, END_IDX is the bias term
//   gate          1 adds value, 0 adds zero
//   value         signed weight or bias
//   exact         1 = exact add, 0 = approximate add (only when APPROX_EN)
//   result        sum > 0 of the last completed unit
//   done          one-cycle pulse when result updates
// Indices above END_IDX are ignored entirely.
module rbm_mac
  import rbm_pkg::*;
#(
  parameter int IDX_W     = 10,
  parameter int END_IDX   = 784,
  parameter bit APPROX_EN = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic             gate,
  input  acc_t             value,
  input  logic             exact,
  output logic             result,
  output logic             done
);

  acc_t acc;
  acc_t term;
  acc_t base;
  acc_t sum;
  logic active;
  logic last;

  assign term   = gate ? value : '0;
  // Index 0 starts a fresh unit, so no separate clear cycle is needed.
  assign base   = (idx == '0) ? '0 : acc;
  assign last   = (idx == IDX_W'(END_IDX));
  assign active = en && (idx <= IDX_W'(END_IDX));

  generate
    if (APPROX_EN) begin : g_approx
      // NOTE: every signal written in always_comb is assigned on all paths,
      // so no latch can be inferred.
      always_comb begin
        sum = base + term;
        if (!exact) begin
          // Masking both operands makes the low bits of the sum zero as well.
          sum = (base & APPROX_KEEP) + (term & APPROX_KEEP);
        end
      end
    end else begin : g_exact
      logic unused_exact;
      assign unused_exact = exact;
      assign sum          = base + term;
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      result <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active) begin
        acc <= sum;
        if (last) begin
          result <= (sum > acc_t'(0));
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rbm_core.sv
// rbm_core: bit-serial inference datapath of a binary RBM classifier.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   h_value, pixel_id   hidden-phase weight/bias and its index
//   pixel               visible bit gating h_value
//   h_switch            1 = exact, 0 = approximate hidden-phase add
//   enable_hidden       hidden phase active
//   enable_classi       classifier phase active
//   c_value, hidden_id  classifier weight/bias and its index
//   hidden_pixel        hidden bit gating c_value
//   hidden, hidden_finish   hidden result and its one-cycle update pulse
//   spike, finish           class result and its one-cycle update pulse
// Both enables high is illegal and treated as idle.
// Build option: define RBM_APPROX_ADDER_EN to honour h_switch; otherwise the
// hidden phase is always exact and the approximate adder is not built.
module rbm_core
  import rbm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [DW-1:0]    h_value,
  input  logic [PIX_W-1:0] pixel_id,
  input  logic             pixel,
  input  logic             h_switch,
  input  logic             enable_hidden,
  input  logic             enable_classi,
  input  logic [DW-1:0]    c_value,
  input  logic [HID_W-1:0] hidden_id,
  input  logic             hidden_pixel,
  output logic             hidden,
  output logic             hidden_finish,
  output logic             spike,
  output logic             finish
);

  logic h_en;
  logic c_en;
  logic h_exact;

  assign h_en = enable_hidden && !enable_classi;
  assign c_en = enable_classi && !enable_hidden;

`ifdef RBM_APPROX_ADDER_EN
  localparam bit H_APPROX = 1'b1;
  assign h_exact = h_switch;
`else
  localparam bit H_APPROX = 1'b0;
  logic unused_h_switch;
  assign unused_h_switch = h_switch;
  assign h_exact         = 1'b1;
`endif

  rbm_mac #(
    .IDX_W     (PIX_W),
    .END_IDX   (N_VIS),
    .APPROX_EN (H_APPROX)
  ) u_hidden_mac (
    .clock  (clock),
    .reset  (reset),
    .en     (h_en),
    .idx    (pixel_id),
    .gate   (pixel),
    .value  (acc_t'(h_value)),
    .exact  (h_exact),
    .result (hidden),
    .done   (hidden_finish)
  );

  rbm_mac #(
    .IDX_W     (HID_W),
    .END_IDX   (N_HID),
    .APPROX_EN (1'b0)
  ) u_class_mac (
    .clock  (clock),
    .reset  (reset),
    .en     (c_en),
    .idx    (hidden_id),
    .gate   (hidden_pixel),
    .value  (acc_t'(c_value)),
    .exact  (1'b1),
    .result (spike),
    .done   (finish)
  );

endmodule

// File: tb/tb_rbm_core.sv
// tb_rbm_core: scoreboard bench for rbm_core. Expected results are queued
// when the bias term is driven and compared when a finish pulse appears.
module tb_rbm_core;
  import rbm_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic [DW-1:0]    h_value;
  logic [PIX_W-1:0] pixel_id;
  logic             pixel;
  logic             h_switch;
  logic             enable_hidden;
  logic             enable_classi;
  logic [DW-1:0]    c_value;
  logic [HID_W-1:0] hidden_id;
  logic             hidden_pixel;
  logic             hidden;
  logic             hidden_finish;
  logic             spike;
  logic             finish;

  rbm_core dut (
    .clock         (clock),
    .reset         (reset),
    .h_value       (h_value),
    .pixel_id      (pixel_id),
    .pixel         (pixel),
    .h_switch      (h_switch),
    .enable_hidden (enable_hidden),
    .enable_classi (enable_classi),
    .c_value       (c_value),
    .hidden_id     (hidden_id),
    .hidden_pixel  (hidden_pixel),
    .hidden        (hidden),
    .hidden_finish (hidden_finish),
    .spike         (spike),
    .finish        (finish)
  );

  always #5 clock = ~clock;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic   val;
    longint cyc;
  } exp_t;

  exp_t q_h[$];
  exp_t q_c[$];

  // Reference state.
  acc_t m_acc_h = '0;
  acc_t m_acc_c = '0;
  logic m_hidden = 1'b0;
  logic m_spike  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic acc_t m_add(input acc_t a, input acc_t b, input bit exact);
`ifdef RBM_APPROX_ADDER_EN
    if (!exact) return (a & APPROX_KEEP) + (b & APPROX_KEEP);
`endif
    return a + b;
  endfunction

  // Scoreboard side: every pulse must match the head of its queue.
  always @(negedge clock) begin
    exp_t e;
    if (hidden_finish === 1'b1) begin
      if (q_h.size() == 0) check("hidden_finish_unexpected", 1, 0);
      else begin
        e = q_h.pop_front();
        check("hidden", {63'd0, hidden}, {63'd0, e.val});
        check("hidden_finish_cycle", cyc, e.cyc);
      end
    end
    if (finish === 1'b1) begin
      if (q_c.size() == 0) check("finish_unexpected", 1, 0);
      else begin
        e = q_c.pop_front();
        check("spike", {63'd0, spike}, {63'd0, e.val});
        check("finish_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic h_term(input int idx, input bit pix, input acc_t val, input bit sw);
    acc_t term;
    acc_t sum;
    enable_hidden = 1'b1;
    enable_classi = 1'b0;
    pixel_id      = PIX_W'(idx);
    pixel         = pix;
    h_value       = val;
    h_switch      = sw;
    term = pix ? val : '0;
    if (idx <= N_VIS) begin
      sum     = m_add((idx == 0) ? acc_t'(0) : m_acc_h, term, sw);
      m_acc_h = sum;
      if (idx == N_VIS) begin
        m_hidden = (sum > acc_t'(0));
        q_h.push_back('{m_hidden, cyc + 1});
      end
    end
    tick();
  endtask

  task automatic c_term(input int idx, input bit hp, input acc_t val);
    acc_t term;
    acc_t sum;
    enable_hidden = 1'b0;
    enable_classi = 1'b1;
    hidden_id     = HID_W'(idx);
    hidden_pixel  = hp;
    c_value       = val;
    term = hp ? val : '0;
    if (idx <= N_HID) begin
      sum     = m_add((idx == 0) ? acc_t'(0) : m_acc_c, term, 1'b1);
      m_acc_c = sum;
      if (idx == N_HID) begin
        m_spike = (sum > acc_t'(0));
        q_c.push_back('{m_spike, cyc + 1});
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    enable_hidden = 1'b0;
    enable_classi = 1'b0;
    repeat (n) tick();
  endtask

  // Full hidden unit with a constant pixel and weight, then the bias.
  task automatic h_unit(input bit pix, input acc_t w, input acc_t bias, input bit sw);
    for (int i = 0; i < N_VIS; i++) h_term(i, pix, w, sw);
    h_term(N_VIS, 1'b1, bias, sw);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_hidden"}, {63'd0, hidden}, 64'd0);
    check({tag, "_spike"}, {63'd0, spike}, 64'd0);
    check({tag, "_hidden_finish"}, {63'd0, hidden_finish}, 64'd0);
    check({tag, "_finish"}, {63'd0, finish}, 64'd0);
  endtask

  initial begin
    reset         = 1'b1;
    h_value       = '0;
    pixel_id      = '0;
    pixel         = 1'b0;
    h_switch      = 1'b1;
    enable_hidden = 1'b0;
    enable_classi = 1'b0;
    c_value       = '0;
    hidden_id     = '0;
    hidden_pixel  = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Threshold boundary: sum exactly 0 gives 0, sum 1 gives 1.
    h_unit(1'b1, acc_t'(1), acc_t'(-784), 1'b1);
    h_unit(1'b1, acc_t'(1), acc_t'(-783), 1'b1);
    idle(2);
    // Implicit restart with no stale contribution.
    h_unit(1'b0, acc_t'(1), acc_t'(5), 1'b1);
    h_unit(1'b0, acc_t'(1), acc_t'(-5), 1'b1);
    idle(1);

    // Approximate versus exact addition of sub-resolution weights.
    h_unit(1'b1, acc_t'(64'h0000_0000_0000_FFFF), acc_t'(1), 1'b0);
    h_unit(1'b1, acc_t'(64'h0000_0000_0000_FFFF), acc_t'(1), 1'b1);

    // Random pixels, weights and per-term switch.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < N_VIS; i++)
        h_term(i, 1'($urandom_range(0, 1)),
               acc_t'(int'($urandom_range(0, 200000)) - 100000),
               1'($urandom_range(0, 1)));
      h_term(N_VIS, 1'b1, acc_t'(int'($urandom_range(0, 400000)) - 200000),
             1'($urandom_range(0, 1)));
    end
    idle(2);

    // Overflow wraps negative: 0x7FFF...F + 1 gives result 0.
    h_unit(1'b0, acc_t'(1), acc_t'(5), 1'b1);
    h_term(0, 1'b1, acc_t'(64'h7FFF_FFFF_FFFF_FFFF), 1'b1);
    h_term(1, 1'b1, acc_t'(1), 1'b1);
    for (int i = 2; i < N_VIS; i++) h_term(i, 1'b0, acc_t'(1000), 1'b1);
    h_term(N_VIS, 1'b1, acc_t'(0), 1'b1);
    idle(1);

    // Classifier: alternating gating, +2 even / -1 odd, bias 0.
    for (int i = 0; i < N_HID; i++)
      c_term(i, ((i >> 1) & 1) == 0, (i % 2 == 0) ? acc_t'(2) : acc_t'(-1));
    c_term(N_HID, 1'b1, acc_t'(0));
    // Ten classes back to back; the last one is forced positive.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N_HID; i++)
        c_term(i, 1'($urandom_range(0, 1)), acc_t'(int'($urandom_range(0, 2000)) - 1000));
      c_term(N_HID, 1'b1, (k == 9) ? acc_t'(64'd1 << 40)
                                   : acc_t'(int'($urandom_range(0, 40000)) - 20000));
    end
    idle(1);

    // Both enables high mid-unit, plus an out-of-range index: no effect.
    for (int i = 0; i < 400; i++) h_term(i, 1'b1, acc_t'(1), 1'b1);
    enable_hidden = 1'b1;
    enable_classi = 1'b1;
    pixel_id      = PIX_W'(N_VIS);
    pixel         = 1'b1;
    h_value       = 64'd1000;
    hidden_id     = HID_W'(N_HID);
    hidden_pixel  = 1'b1;
    c_value       = 64'd1000;
    repeat (4) tick();
    @(negedge clock);
    check("illegal_hidden", {63'd0, hidden}, {63'd0, m_hidden});
    check("illegal_spike", {63'd0, spike}, {63'd0, m_spike});
    h_term(1000, 1'b1, acc_t'(5000), 1'b1);
    for (int i = 400; i < N_VIS; i++) h_term(i, 1'b1, acc_t'(1), 1'b1);
    h_term(N_VIS, 1'b1, acc_t'(-784), 1'b1);
    idle(1);

    // Reset mid-accumulation discards the partial sum.
    h_unit(1'b0, acc_t'(1), acc_t'(5), 1'b1);
    for (int i = 0; i < 100; i++) h_term(i, 1'b1, acc_t'(1), 1'b1);
    reset    = 1'b1;
    pixel_id = PIX_W'(100);
    tick();
    @(negedge clock);
    check_outputs_zero("mid_reset");
    m_acc_h  = '0;
    m_acc_c  = '0;
    m_hidden = 1'b0;
    m_spike  = 1'b0;
    reset    = 1'b0;
    for (int i = 101; i < N_VIS; i++) h_term(i, 1'b1, acc_t'(1), 1'b1);
    h_term(N_VIS, 1'b1, acc_t'(-700), 1'b1);
    idle(3);

    @(negedge clock);
    check("hidden_hold", {63'd0, hidden}, {63'd0, m_hidden});
    check("spike_hold", {63'd0, spike}, {63'd0, m_spike});
    check("hidden_queue_drained", 64'(q_h.size()), 64'd0);
    check("class_queue_drained", 64'(q_c.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
